// File: rtl/rob_dispatch_ctrl.sv
// rob_dispatch_ctrl: rename-to-ROB allocation sequencer with retry on partial grants.
// Optional allocation-stall counter enabled by defining ROB_DISP_STALL_CNT_EN.
package uarch_pkg;
    parameter int TAG_WIDTH = 6;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  ard;
        logic [6:0]  prd;
        logic        exc;
    } rob_entry_t;
endpackage

module rob_dispatch_ctrl
    import uarch_pkg::rob_entry_t;
#(
    parameter int PIPE_WIDTH  = 2,
    parameter int TAG_WIDTH   = uarch_pkg::TAG_WIDTH,
    parameter int STALL_CNT_W = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic [PIPE_WIDTH-1:0]                in_valid,
    input  rob_entry_t [PIPE_WIDTH-1:0]          in_entries,
    output logic                                 in_ready,
    output logic [PIPE_WIDTH-1:0]                rob_alloc_req,
    input  logic [PIPE_WIDTH-1:0]                rob_alloc_gnt,
    input  logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] rob_alloc_tags,
    output logic [PIPE_WIDTH-1:0]                rob_we,
    output rob_entry_t [PIPE_WIDTH-1:0]          rob_entries,
    output logic [PIPE_WIDTH-1:0]                disp_valid,
    output logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] disp_tags,
    output logic [STALL_CNT_W-1:0]               stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GNT  = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    rob_entry_t [PIPE_WIDTH-1:0] hold_q, hold_d;
    logic [PIPE_WIDTH-1:0]       hold_valid_q, hold_valid_d;
    logic [PIPE_WIDTH-1:0]       g;
    logic                        accept;

    // The ROB grants oldest-first, so a lone slot1 grant is not honoured.
    always_comb begin
        g = rob_alloc_gnt & hold_valid_q;
        if (g == 2'b10) begin
            g = 2'b00;
        end
    end

    assign accept = (state_q == IDLE) && !flush && (|in_valid);

    always_comb begin
        in_ready      = rst_n && (state_q == IDLE) && !flush;
        rob_alloc_req = '0;
        rob_we        = '0;
        if (!flush && state_q == REQ) begin
            rob_alloc_req = hold_valid_q;
        end
        if (!flush && state_q == GNT) begin
            rob_we = g;
        end
        disp_valid  = rob_we;
        rob_entries = hold_q;
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            disp_tags[i] = rob_we[i] ? rob_alloc_tags[i] : '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (flush) begin
            state_d      = IDLE;
            hold_valid_d = '0;
        end else begin
            unique case (1'b1)
                state_q == IDLE: begin
                    if (accept) begin
                        state_d = REQ;
                        if (in_valid == 2'b10) begin
                            hold_d[0]    = in_entries[1];
                            hold_valid_d = 2'b01;
                        end else begin
                            hold_d       = in_entries;
                            hold_valid_d = in_valid;
                        end
                    end
                end
                state_q == REQ: begin
                    state_d = GNT;
                end
                state_q == GNT: begin
                    if (g == hold_valid_q) begin
                        state_d      = IDLE;
                        hold_valid_d = '0;
                    end else if (g == 2'b01 && hold_valid_q == 2'b11) begin
                        state_d      = REQ;
                        hold_d[0]    = hold_q[1];
                        hold_valid_d = 2'b01;
                    end else begin
                        state_d = REQ;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    hold_valid_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

`ifdef ROB_DISP_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counts partial and zero grants; survives flush, saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!flush && state_q == GNT && g != hold_valid_q && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rob_dispatch_ctrl.sv
// Directed bench for rob_dispatch_ctrl: full, partial, zero grants, compaction,
// flush and asynchronous reset, with hand-computed expectations.
module tb_rob_dispatch_ctrl;
    import uarch_pkg::*;

    localparam int TW = uarch_pkg::TAG_WIDTH;
`ifdef ROB_DISP_STALL_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush;
    logic [1:0]          in_valid;
    rob_entry_t [1:0]    in_entries;
    logic                in_ready;
    logic [1:0]          rob_alloc_req;
    logic [1:0]          rob_alloc_gnt;
    logic [1:0][TW-1:0]  rob_alloc_tags;
    logic [1:0]          rob_we;
    rob_entry_t [1:0]    rob_entries;
    logic [1:0]          disp_valid;
    logic [1:0][TW-1:0]  disp_tags;
    logic [31:0]         stall_cnt;
    logic [1:0][TW-1:0]  exp_tags;

    int n_cmp = 0;
    int n_err = 0;

    rob_dispatch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_entries     (in_entries),
        .in_ready       (in_ready),
        .rob_alloc_req  (rob_alloc_req),
        .rob_alloc_gnt  (rob_alloc_gnt),
        .rob_alloc_tags (rob_alloc_tags),
        .rob_we         (rob_we),
        .rob_entries    (rob_entries),
        .disp_valid     (disp_valid),
        .disp_tags      (disp_tags),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rob_entry_t ent(input logic [31:0] pc);
        ent     = '0;
        ent.pc  = pc;
        ent.ard = pc[6:2];
        ent.prd = pc[8:2];
    endfunction

    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
        in_valid      = v;
        in_entries[0] = ent(pc0);
        in_entries[1] = ent(pc1);
    endtask

    initial begin
        rst_n          = 1'b0;
        flush          = 1'b0;
        in_valid       = '0;
        in_entries     = '0;
        rob_alloc_gnt  = '0;
        rob_alloc_tags = '0;
        #2;
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_req", 64'(rob_alloc_req), 64'd0);
        chk("rst_we", 64'(rob_we), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle_ready", 64'(in_ready), 64'd1);

        // full grant
        drive(2'b11, 32'h100, 32'h104);
        #1;
        chk("t1_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = '0;
        #1;
        chk("t1_req", 64'(rob_alloc_req), 64'd3);
        chk("t1_busy", 64'(in_ready), 64'd0);
        chk("t1_we_req", 64'(rob_we), 64'd0);
        tick();
        rob_alloc_gnt     = 2'b11;
        rob_alloc_tags[0] = TW'(0);
        rob_alloc_tags[1] = TW'(1);
        #1;
        exp_tags[0] = TW'(0);
        exp_tags[1] = TW'(1);
        chk("t1_we", 64'(rob_we), 64'd3);
        chk("t1_disp", 64'(disp_valid), 64'd3);
        chk("t1_tags", 64'(disp_tags), 64'(exp_tags));
        chk("t1_pc0", 64'(rob_entries[0].pc), 64'h100);
        chk("t1_pc1", 64'(rob_entries[1].pc), 64'h104);
        chk("t1_req_gnt", 64'(rob_alloc_req), 64'd0);
        tick();
        rob_alloc_gnt = '0;
        #1;
        chk("t1_ready_n3", 64'(in_ready), 64'd1);

        // partial grant, then wrap-around tag for slot1
        drive(2'b11, 32'h100, 32'h104);
        tick();
        in_valid = '0;
        #1;
        chk("t2_req", 64'(rob_alloc_req), 64'd3);
        tick();
        rob_alloc_gnt     = 2'b01;
        rob_alloc_tags[0] = TW'(7);
        rob_alloc_tags[1] = TW'(3);
        #1;
        chk("t2_we1", 64'(rob_we), 64'd1);
        chk("t2_tag0", 64'(disp_tags[0]), 64'd7);
        chk("t2_tag1", 64'(disp_tags[1]), 64'd0);
        chk("t2_pc0", 64'(rob_entries[0].pc), 64'h100);
        tick();
        rob_alloc_gnt = '0;
        #1;
        chk("t2_req2", 64'(rob_alloc_req), 64'd1);
        chk("t2_shift", 64'(rob_entries[0].pc), 64'h104);
        tick();
        rob_alloc_gnt     = 2'b01;
        rob_alloc_tags[0] = TW'(0);
        rob_alloc_tags[1] = TW'(5);
        #1;
        chk("t2_we2", 64'(rob_we), 64'd1);
        chk("t2_pc_wr", 64'(rob_entries[0].pc), 64'h104);
        chk("t2_tag_wr", 64'(disp_tags), 64'd0);
        tick();
        rob_alloc_gnt = '0;
        #1;
        chk("t2_ready", 64'(in_ready), 64'd1);
        chk("t2_stall", 64'(stall_cnt), 64'(CNT_EN));

        // zero grants (one an illegal 10) before a full grant
        drive(2'b11, 32'h200, 32'h204);
        tick();
        in_valid = '0;
        #1;
        chk("t3_req0", 64'(rob_alloc_req), 64'd3);
        for (int k = 0; k < 3; k++) begin
            tick();
            rob_alloc_gnt = (k == 1) ? 2'b10 : 2'b00;
            #1;
            chk("t3_we_zero", 64'(rob_we), 64'd0);
            chk("t3_req_gap", 64'(rob_alloc_req), 64'd0);
            tick();
            rob_alloc_gnt = '0;
            #1;
            chk("t3_req_retry", 64'(rob_alloc_req), 64'd3);
        end
        tick();
        rob_alloc_gnt     = 2'b11;
        rob_alloc_tags[0] = TW'(8);
        rob_alloc_tags[1] = TW'(9);
        #1;
        exp_tags[0] = TW'(8);
        exp_tags[1] = TW'(9);
        chk("t3_we", 64'(rob_we), 64'd3);
        chk("t3_tags", 64'(disp_tags), 64'(exp_tags));
        chk("t3_pc1", 64'(rob_entries[1].pc), 64'h204);
        tick();
        rob_alloc_gnt = '0;
        #1;
        chk("t3_ready", 64'(in_ready), 64'd1);
        chk("t3_stall", 64'(stall_cnt), 64'(CNT_EN * 4));

        // compaction of pattern 10
        drive(2'b10, 32'hdead0, 32'h108);
        #1;
        chk("t4_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = '0;
        #1;
        chk("t4_req", 64'(rob_alloc_req), 64'd1);
        chk("t4_pc0", 64'(rob_entries[0].pc), 64'h108);
        tick();
        rob_alloc_gnt     = 2'b11;
        rob_alloc_tags[0] = TW'(2);
        rob_alloc_tags[1] = TW'(3);
        #1;
        chk("t4_we", 64'(rob_we), 64'd1);
        chk("t4_tag0", 64'(disp_tags[0]), 64'd2);
        tick();
        rob_alloc_gnt = '0;
        #1;
        chk("t4_ready2", 64'(in_ready), 64'd1);
        chk("t4_stall", 64'(stall_cnt), 64'(CNT_EN * 4));

        // flush during GNT discards the grant
        drive(2'b11, 32'h300, 32'h304);
        tick();
        in_valid = '0;
        #1;
        chk("t5_req", 64'(rob_alloc_req), 64'd3);
        tick();
        rob_alloc_gnt = 2'b11;
        flush         = 1'b1;
        #1;
        chk("t5_we", 64'(rob_we), 64'd0);
        chk("t5_disp", 64'(disp_valid), 64'd0);
        chk("t5_ready", 64'(in_ready), 64'd0);
        tick();
        rob_alloc_gnt = '0;
        flush         = 1'b0;
        #1;
        chk("t5_idle", 64'(in_ready), 64'd1);
        chk("t5_noreq", 64'(rob_alloc_req), 64'd0);
        drive(2'b11, 32'h400, 32'h404);
        tick();
        in_valid = '0;
        #1;
        chk("t5_req2", 64'(rob_alloc_req), 64'd3);
        chk("t5_pc0", 64'(rob_entries[0].pc), 64'h400);
        tick();
        rob_alloc_gnt = 2'b11;
        #1;
        chk("t5_we2", 64'(rob_we), 64'd3);
        tick();
        rob_alloc_gnt = '0;
        flush         = 1'b1;
        drive(2'b11, 32'h500, 32'h504);
        #1;
        chk("t5_flush_idle", 64'(in_ready), 64'd0);
        tick();
        flush    = 1'b0;
        in_valid = '0;
        #1;
        chk("t5_no_accept", 64'(rob_alloc_req), 64'd0);

        // asynchronous reset in REQ
        drive(2'b11, 32'h600, 32'h604);
        tick();
        in_valid = '0;
        #1;
        chk("t6_req", 64'(rob_alloc_req), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req_async", 64'(rob_alloc_req), 64'd0);
        chk("t6_ready_rst", 64'(in_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_ready", 64'(in_ready), 64'd1);
        chk("t6_stall", 64'(stall_cnt), 64'd0);
        tick();
        #1;
        chk("t6_lost", 64'(rob_alloc_req), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rob_dispatch_ctrl.md
# rob_dispatch_ctrl

Sequencer between rename and the ROB.
- Accepts a bundle of up to two renamed instructions from rename.
- Runs the two-phase ROB handshake: allocation request, then grant/tag return with entry write.
- Retries partial or refused grants until every instruction in the bundle holds a ROB tag.
- Presents the granted tags and valids to the reservation-station dispatch path. Flush from the ROB aborts any bundle in flight.

## Interface
Parameters:
- PIPE_WIDTH, 2, slots per bundle; fixed at 2, other values unsupported.
- TAG_WIDTH, uarch_pkg::TAG_WIDTH, ROB tag width.
- STALL_CNT_W, 32, stall counter width (used only with the macro in Configuration).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  ROB flush; kills the held bundle.
- in_valid  in  2  rename slot valids; legal patterns are 00, 01, 11.
- in_entries  in  rob_entry_t x2  rename payload.
- in_ready  out  1  bundle accepted on a clock edge where (|in_valid && in_ready).
- rob_alloc_req  out  2  allocation request to the ROB.
- rob_alloc_gnt  in  2  ROB grant; valid in the cycle after the request; oldest-first.
- rob_alloc_tags  in  TAG_WIDTH x2  tags accompanying the grant.
- rob_we  out  2  ROB entry write enables.
- rob_entries  out  rob_entry_t x2  entries written into the ROB.
- disp_valid  out  2  slot dispatched to the RS this cycle (equals rob_we).
- disp_tags  out  TAG_WIDTH x2  ROB tag per dispatched slot.
- stall_cnt  out  STALL_CNT_W  allocation stall cycles.

## Operation
Storage and registers:
- Hold buffer: two rob_entry_t plus hold_valid[1:0].
- FSM with states IDLE, REQ, GNT.

Reset:
- State IDLE, hold_valid 00, stall_cnt 0.
- Every output is 0, including in_ready while rst_n is low.

IDLE:
- in_ready = !flush.
- On acceptance, the bundle is written into the hold buffer and the state moves to REQ.
- Pattern 10 is compacted: slot1 is moved to slot0 and hold_valid becomes 01.
- Patterns 01 and 11 are stored as-is.

REQ:
- rob_alloc_req = hold_valid for exactly one cycle, then the state moves to GNT.
- in_ready is 0.

GNT, with g = rob_alloc_gnt & hold_valid:
- rob_we = g; rob_entries = hold buffer; disp_valid = g; disp_tags[i] = rob_alloc_tags[i].
- g == hold_valid: clear the buffer and go to IDLE.
- g == 01 with hold_valid == 11: move slot1 to slot0, set hold_valid = 01, go to REQ.
- g == 00: keep the buffer and go to REQ.
- A grant of 10 cannot occur because the ROB grants oldest-first. If it does, the controller treats it as 00.

Flush:
- Flush has priority over every transition in every state.
- In the flush cycle, rob_alloc_req, rob_we, disp_valid and in_ready are forced to 0 combinationally.
- On the next edge: state IDLE, hold_valid 00.
- A grant arriving in a flush cycle is discarded.

Other rules:
- rob_alloc_req is never asserted in two consecutive cycles.
- Entry ordering is preserved: slot0 is always older than slot1.

## Timing
- Bundle accepted at edge N: rob_alloc_req is high in cycle N+1, and gnt/we/disp are visible in cycle N+2.
- Full-grant throughput: one bundle per 3 cycles (IDLE, REQ, GNT).
- Each partial or zero grant adds 2 cycles (REQ, GNT).
- rob_we and rob_entries are combinational from the hold buffer and the grant, valid in GNT and held until the edge.
- in_ready is combinational from the state and flush; there is no combinational path from in_valid to in_ready.
- Reset mid-handshake: the outputs drop to 0 asynchronously, and the bundle is lost.

## Configuration
ROB_DISP_STALL_CNT_EN:
- Defined: stall_cnt increments by 1 on every GNT cycle where g != hold_valid (partial or zero grant). It saturates at all-ones, is cleared by reset, and is not cleared by flush.
- Undefined: no counter logic; stall_cnt is tied to 0.

## Test plan
- Full grant: accept in_valid 11 (pc 0x100, 0x104); ROB returns gnt 11 with tags 0, 1 → in cycle N+2, rob_we 11, disp_tags {0, 1}, entry pcs 0x100/0x104; in_ready 1 in cycle N+3.
- Partial grant: bundle 11, first gnt 01 with tag 7 → slot0 (0x100) written with tag 7. REQ re-issues req 01, carrying slot1 (0x104) now in position 0. Second gnt 01 with tag 0 (wrap) → 0x104 written on rob_we[0] with tag 0. With the macro: stall_cnt = 1.
- Zero grant (ROB full): gnt 00 three times, then 11 → no rob_we until the fourth GNT; req pulses are separated by at least one low cycle. With the macro: stall_cnt = 3.
- Compaction: in_valid 10 with pc 0x108 in slot1 → rob_alloc_req 01; rob_entries[0].pc = 0x108.
- Flush in GNT with gnt 11 → rob_we 00 in that cycle; state IDLE and in_ready 1 in the next cycle; the next bundle's req is 11.
- Async reset asserted in REQ → rob_alloc_req falls without waiting for a clock edge; after release, in_ready is 1 and stall_cnt is 0.
